// File: rtl/wm_phase_timer.sv
// Phase-duration timer for the washing machine controller: pulses tempo when the active phase's time is up.
// Optional remaining-seconds output enabled by defining WM_TIMER_REMAIN_EN.
module wm_phase_timer #(
    parameter int TICK_DIV  = 50000000,
    parameter int CNT_W     = 8,
    parameter int T_MOLHO   = 30,
    parameter int T_LAVAR   = 60,
    parameter int T_ENXAGUE = 40,
    parameter int T_CENTRIF = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             molho,
    input  logic             lavar,
    input  logic             enxague,
    input  logic             centrifugar,
    input  logic             pausar,
    output logic             tempo,
    output logic             busy,
`ifdef WM_TIMER_REMAIN_EN
    output logic [CNT_W-1:0] restante,
`endif
    output logic             fault
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Zero-length phases still take one second so every phase produces a pulse.
    localparam logic [CNT_W-1:0] D_MOLHO   = CNT_W'((T_MOLHO   < 1) ? 1 : T_MOLHO);
    localparam logic [CNT_W-1:0] D_LAVAR   = CNT_W'((T_LAVAR   < 1) ? 1 : T_LAVAR);
    localparam logic [CNT_W-1:0] D_ENXAGUE = CNT_W'((T_ENXAGUE < 1) ? 1 : T_ENXAGUE);
    localparam logic [CNT_W-1:0] D_CENTRIF = CNT_W'((T_CENTRIF < 1) ? 1 : T_CENTRIF);

    typedef enum logic [2:0] {
        PH_NONE, PH_SOAK, PH_WASH, PH_RINSE, PH_SPIN, PH_PAUSE, PH_FAULT
    } phase_t;

    phase_t           phase, last, last_n;
    logic [CNT_W-1:0] cnt, cnt_n, load_val;
    logic [PRE_W-1:0] pre, pre_n;
    logic             tempo_n, busy_n, fault_n;
    logic [2:0]       n_hi;

    always_comb begin
        n_hi = {2'b0, molho} + {2'b0, lavar} + {2'b0, enxague}
             + {2'b0, centrifugar} + {2'b0, pausar};
        phase = PH_NONE;
        if (n_hi > 3'd1)      phase = PH_FAULT;
        else if (molho)       phase = PH_SOAK;
        else if (lavar)       phase = PH_WASH;
        else if (enxague)     phase = PH_RINSE;
        else if (centrifugar) phase = PH_SPIN;
        else if (pausar)      phase = PH_PAUSE;
    end

    always_comb begin
        case (phase)
            PH_SOAK:  load_val = D_MOLHO;
            PH_WASH:  load_val = D_LAVAR;
            PH_RINSE: load_val = D_ENXAGUE;
            default:  load_val = D_CENTRIF;
        endcase
    end

    always_comb begin
        last_n  = last;
        cnt_n   = cnt;
        pre_n   = pre;
        busy_n  = busy;
        tempo_n = 1'b0;
        fault_n = 1'b0;
        case (phase)
            PH_NONE: begin
                last_n = PH_NONE;
                cnt_n  = '0;
                pre_n  = '0;
                busy_n = 1'b0;
            end
            PH_PAUSE: ;
            PH_FAULT: fault_n = 1'b1;
            default: begin
                // Load wins over any tick that would have landed on this edge.
                if (phase != last) begin
                    last_n = phase;
                    cnt_n  = load_val;
                    pre_n  = '0;
                    busy_n = 1'b1;
                end else if (cnt != '0) begin
                    if (pre == PRE_MAX) begin
                        pre_n = '0;
                        cnt_n = cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            tempo_n = 1'b1;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        pre_n = pre + {{(PRE_W-1){1'b0}}, 1'b1};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last  <= PH_NONE;
            cnt   <= '0;
            pre   <= '0;
            tempo <= 1'b0;
            busy  <= 1'b0;
            fault <= 1'b0;
        end else begin
            last  <= last_n;
            cnt   <= cnt_n;
            pre   <= pre_n;
            tempo <= tempo_n;
            busy  <= busy_n;
            fault <= fault_n;
        end
    end

`ifdef WM_TIMER_REMAIN_EN
    assign restante = cnt;
`endif

endmodule
